// File: rtl/ex_commit_arbiter.sv
// Exception/interrupt/eret commit arbiter at the WB -> CP0 boundary; optional macro EX_COMMIT_HWINT_EN.
// Latency: CP0 controls pulse 1 cycle after acceptance, flush for FLUSH_CYCLES, then a 1-cycle redirect.
// Backpressure: none; WB instructions seen while flushing/redirecting are dropped, not stalled.

`ifndef NO_EX
`define NO_EX 5'h1f
`endif
`ifndef INT
`define INT   5'h00
`endif
`ifndef ADEL
`define ADEL  5'h04
`endif
`ifndef ADES
`define ADES  5'h05
`endif
`ifndef SYS
`define SYS   5'h08
`endif

module ex_commit_arbiter #(
    parameter int unsigned FLUSH_CYCLES = 2,            // 1..15
    parameter logic [31:0] EX_ENTRY     = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic [4:0]  wb_ex_code,
    input  logic [31:0] wb_badvaddr,
    input  logic        wb_pc_err,
    input  logic        wb_eret,
    input  logic [5:0]  hw_int,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_epc,
    output logic [4:0]  ex_code,
    output logic        bd,
    output logic        eret,
    output logic [31:0] BadVAddr,
    output logic        pc_error,
    output logic [31:0] ex_pc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

    state_t      state;
    logic [3:0]  flush_cnt;
    logic [31:0] redir_target;
    logic [5:0]  hw_sync;
    logic [7:0]  ip_eff;
    logic        int_req;
    logic        take_ex;
    logic        take_eret;
    logic        accept;

`ifdef EX_COMMIT_HWINT_EN
    logic [5:0] hw_meta;

    // Two-flop synchronizer for the asynchronous external interrupt lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            hw_meta <= 6'd0;
            hw_sync <= 6'd0;
        end else begin
            hw_meta <= hw_int;
            hw_sync <= hw_meta;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{cp0_cause[31:16], cp0_cause[7:0], cp0_status[31:16], cp0_status[7:2]};
`else
    assign hw_sync = 6'd0;

    logic unused_bits;
    assign unused_bits = ^{hw_int, cp0_cause[31:16], cp0_cause[7:0], cp0_status[31:16], cp0_status[7:2]};
`endif

    // Interrupt request and event selection; interrupts outrank the instruction's own exception and eret.
    always_comb begin
        ip_eff    = cp0_cause[15:8] | {hw_sync, 2'b00};
        int_req   = cp0_status[0] & ~cp0_status[1] & (|(cp0_status[15:8] & ip_eff));
        take_ex   = int_req | (wb_ex_code != `NO_EX);
        take_eret = ~take_ex & wb_eret;
        // A pending interrupt without a valid WB instruction waits: EPC needs a real PC.
        accept    = (state == IDLE) & wb_valid & (take_ex | wb_eret);
    end

    // Commit FSM: registered CP0 pulse, timed flush window, single redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            flush_cnt      <= 4'd0;
            redir_target   <= 32'd0;
            ex_code        <= `NO_EX;
            bd             <= 1'b0;
            eret           <= 1'b0;
            BadVAddr       <= 32'd0;
            pc_error       <= 1'b0;
            ex_pc          <= 32'd0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            // CP0 controls and redirect are single-cycle pulses by default.
            ex_code        <= `NO_EX;
            bd             <= 1'b0;
            eret           <= 1'b0;
            BadVAddr       <= 32'd0;
            pc_error       <= 1'b0;
            ex_pc          <= 32'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ex_code      <= take_eret ? `NO_EX : (int_req ? `INT : wb_ex_code);
                        eret         <= take_eret;
                        bd           <= wb_bd;
                        ex_pc        <= wb_pc;
                        BadVAddr     <= wb_badvaddr;
                        pc_error     <= wb_pc_err;
                        // EPC is captured now; CP0 may change it before the redirect.
                        redir_target <= take_eret ? cp0_epc : EX_ENTRY;
                        flush        <= 1'b1;
                        flush_cnt    <= 4'(FLUSH_CYCLES - 1);
                        state        <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= redir_target;
                        state          <= REDIR;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                REDIR: begin
                    state <= IDLE;
                end
                default: begin
                    flush <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ex_commit_arbiter.md
Name: ex_commit_arbiter

Overview:
- Sits at the write-back boundary, directly upstream of the CP0 block.
- Each cycle, decides whether the retiring WB instruction raises an exception, takes an interrupt, or executes eret.
- Drives the CP0 control inputs (ex_code, bd, eret, BadVAddr, pc_error, EPC source PC) as a registered one-cycle pulse.
- Flushes the pipeline for a fixed number of cycles, then issues a single fetch redirect to the exception entry or to EPC.

Parameters:
- FLUSH_CYCLES, 2: cycles flush stays high after commit; legal range 1..15.
- EX_ENTRY, 32'hbfc00380: redirect target for every exception and interrupt.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  WB holds a valid retiring instruction
- wb_pc  in  32  PC of the WB instruction
- wb_bd  in  1  WB instruction is in a branch delay slot
- wb_ex_code  in  5  exception code from earlier stages; `NO_EX when none
- wb_badvaddr  in  32  faulting address for `ADEL/`ADES
- wb_pc_err  in  1  the fault is a fetch address error
- wb_eret  in  1  WB instruction is eret
- hw_int  in  6  asynchronous external interrupt lines
- cp0_cause  in  32  CP0 cause register
- cp0_status  in  32  CP0 status register
- cp0_epc  in  32  CP0 EPC register
- ex_code  out  5  to CP0
- bd  out  1  to CP0
- eret  out  1  to CP0
- BadVAddr  out  32  to CP0
- pc_error  out  1  to CP0
- ex_pc  out  32  to CP0 wdata (EPC source)
- flush  out  1  kill all pipeline stages
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target

Behaviour:
- Reset values: ex_code=`NO_EX; all other outputs 0; state IDLE; sync flops 0.
- Interrupt request:
  - ip_eff = cp0_cause[15:8] | {hw_sync,2'b00}.
  - int_req = status[0] & ~status[1] & |(status[15:8] & ip_eff).
- Event acceptance happens only in IDLE with wb_valid=1. Priority, highest first:
  1. int_req: code `INT (0). The instruction's own exception and eret are suppressed.
  2. wb_ex_code != `NO_EX: that code.
  3. wb_eret.
- int_req with wb_valid=0: nothing is taken. The request stays pending and tags the first valid WB instruction, because EPC needs a PC.
- Commit cycle, the cycle after acceptance (registered outputs, one cycle only):
  - ex_code=code, bd=wb_bd, ex_pc=wb_pc.
  - BadVAddr=wb_badvaddr and pc_error=wb_pc_err.
  - For eret: eret=1 and ex_code=`NO_EX.
  - All of these return to reset values the cycle after.
- State machine: IDLE -> FLUSH -> REDIR -> IDLE.
  - IDLE -> FLUSH on acceptance. flush=1 starts in the commit cycle and lasts exactly FLUSH_CYCLES cycles, timed by a down-counter.
  - FLUSH -> REDIR when the counter reaches 0.
  - REDIR: redirect_valid=1 for one cycle. redirect_pc=EX_ENTRY for exceptions and interrupts, or the cp0_epc value captured at acceptance for eret.
  - REDIR -> IDLE.
- wb_valid in FLUSH or REDIR is a flushed instruction: ignored, never committed.
- status.exl=1 blocks interrupts only. Synchronous exceptions are still committed and redirected; CP0 leaves EPC unchanged in that case.
- Back-to-back events are impossible: the next acceptance is at least FLUSH_CYCLES+2 cycles after the previous one.
- Reset in any state: IDLE next cycle, all outputs at reset values, pending redirect dropped.

Optional Feature:
- Macro EX_COMMIT_HWINT_EN.
- Defined: hw_int passes through a 2-flop synchronizer (hw_sync) and is ORed into ip_eff[7:2]; ip_eff[7] also carries the CP0 timer bit.
- Undefined: hw_int ignored, hw_sync=0; interrupts come only from cp0_cause[15:8].

Test Plan:
- Reset: reset high 2 cycles -> ex_code=`NO_EX, flush=0, redirect_valid=0, eret=0.
- Syscall: wb_valid=1, wb_ex_code=`SYS (8), wb_pc=32'hbfc00100, bd=0 ->
  - T+1: ex_code=8, ex_pc=32'hbfc00100 (one cycle).
  - flush high at T+1..T+2.
  - T+3: redirect_valid=1, redirect_pc=32'hbfc00380.
- Eret: cp0_epc=32'hbfc00200, wb_eret=1 ->
  - T+1: eret pulse, ex_code=`NO_EX.
  - T+3: redirect_pc=32'hbfc00200.
- HW interrupt (macro on): status=32'h0000ff01, hw_int[0]=1, wb_valid=0 for 4 cycles, then an instruction with wb_ex_code=`SYS arrives ->
  - ex_code=0 with that instruction's PC.
  - SYS suppressed.
- EXL block: status=32'h0000ff03 with int_req sources active -> no interrupt; a `ADEL instruction with badvaddr 32'h00000003 still commits with BadVAddr=32'h00000003.
- Reset mid-flush: reset asserted in the first FLUSH cycle -> next cycle flush=0, and redirect_valid never asserts.
